pc_sequencer: RTL
=================

# pc_sequencer

Program-counter and return-address-stack unit of the Reaper core. It consumes the control word from the instruction decoder (Jump_I, Jump_R, Branch, Stack_Enable, Stack_Write, Halt) together with the ALU branch result, and produces the registered instruction-memory address for the next cycle. It owns the hardware call stack used by JAL/RET and the run/halt state of the core.

## Interface
- ADDR_WIDTH, 10, instruction address width; PC wraps modulo 2^ADDR_WIDTH
- STACK_DEPTH, 16, return-stack entries (power of two, ≥2)
- Clk  in  1  core clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Halt  in  1  decoder HALT
- Resume  in  1  single-cycle pulse; leaves HALTED
- Stall  in  1  freeze PC and stack this cycle (IO wait)
- Jump_I, Jump_R, Branch, Stack_Enable, Stack_Write  in  1 each  decoder controls
- Branch_Taken  in  1  ALU compare result (1 = condition true)
- Imm_Addr  in  ADDR_WIDTH  immediate target (J, JAL, branches)
- Reg_Addr  in  ADDR_WIDTH  register target (JR)
- PC  out  ADDR_WIDTH  current instruction address
- Halted  out  1  state is HALTED
- Fault  out  1  state is FAULT
- Stack_Overflow, Stack_Underflow  out  1 each  sticky error flags
- Stack_Count  out  $clog2(STACK_DEPTH)+1  live entries

## Operation
- States: RUN, HALTED, FAULT. Reset → RUN.
- RUN, per cycle, first matching rule wins:
  - Stall=1: hold everything.
  - Halt=1: hold PC, → HALTED.
  - Stack_Enable & Stack_Write (JAL): push PC+1, PC ← Imm_Addr, count+1.
  - Stack_Enable & !Stack_Write (RET): PC ← top entry, count−1.
  - Jump_R: PC ← Reg_Addr.
  - Jump_I: PC ← Imm_Addr.
  - Branch & Branch_Taken: PC ← Imm_Addr.
  - otherwise PC ← PC+1 (including Branch with Branch_Taken=0).
- HALTED: PC held; Resume=1 → PC ← PC+1, → RUN. Stall and all controls ignored.
- FAULT: PC held; only Reset exits. Resume ignored.
- Resume in RUN or FAULT has no effect.
- Stack is LIFO; push to full or pop from empty is an error (see Configuration).
- PC+1 wraps: 2^ADDR_WIDTH−1 → 0. JAL at last address pushes 0.

## Timing
- PC is a register; control sampled at edge N sets PC visible after edge N (one-cycle latency, no bubbles).
- Push/pop and PC update in the same edge; top entry read combinationally from current pointer.
- Halted/Fault assert the cycle after the triggering edge.
- Reset (async, any state, mid-call): PC=0, state RUN, Halted=0, Fault=0, both error flags 0, Stack_Count=0; stack contents don't-care.
- Reset deassertion: first fetch from address 0 on next edge.

## Configuration
- RET_STACK_CHECK_EN defined: JAL with Stack_Count=STACK_DEPTH sets Stack_Overflow, no push, PC held, → FAULT; RET with Stack_Count=0 sets Stack_Underflow, PC held, → FAULT. Flags sticky until Reset.
- Undefined: no checks; pointer wraps modulo STACK_DEPTH (overflow overwrites oldest, underflow returns stale entry), Stack_Count saturates at 0/STACK_DEPTH, Stack_Overflow, Stack_Underflow and Fault tied 0, FAULT state unreachable.

## Test plan
- Reset then 5 idle cycles → PC 0,1,2,3,4,5; Halted=0; Stack_Count=0.
- At PC=3 JAL Imm_Addr=0x40, next cycle RET → PC=0x40 then PC=4; Stack_Count 1 then 0.
- Branch with Branch_Taken=0 at PC=7 → 8; Branch_Taken=1, Imm_Addr=0x20 → 0x20; Jump_R Reg_Addr=0x155 → 0x155; PC=0x3FF idle → 0x000.
- Halt at PC=9 → PC stays 9, Halted=1 for 10 cycles with jumps asserted; Resume pulse → PC=10, Halted=0; Stall=1 for 3 cycles holds PC at 10.
- With RET_STACK_CHECK_EN: 17 consecutive JALs → 17th sets Stack_Overflow=1, Fault=1, PC frozen; Resume no effect; RET on empty stack after Reset → Stack_Underflow=1, Fault=1, PC=1 held. Without macro: 17th JAL wraps, flags stay 0.
- Assert Reset asynchronously mid-cycle with Stack_Count=3 and Halted=1 → all outputs at reset values before next edge; fetch resumes at 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter, return-address stack and run/halt/fault state for the Reaper core.
// Optional RET_STACK_CHECK_EN: traps stack overflow/underflow into a sticky FAULT state.
module pc_sequencer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int STACK_DEPTH = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Halt,
  input  logic                           Resume,
  input  logic                           Stall,
  input  logic                           Jump_I,
  input  logic                           Jump_R,
  input  logic                           Branch,
  input  logic                           Stack_Enable,
  input  logic                           Stack_Write,
  input  logic                           Branch_Taken,
  input  logic [ADDR_WIDTH-1:0]          Imm_Addr,
  input  logic [ADDR_WIDTH-1:0]          Reg_Addr,
  output logic [ADDR_WIDTH-1:0]          PC,
  output logic                           Halted,
  output logic                           Fault,
  output logic                           Stack_Overflow,
  output logic                           Stack_Underflow,
  output logic [$clog2(STACK_DEPTH):0]   Stack_Count
);
  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n, pc_inc, top;
  logic [PW-1:0]         sp, sp_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  push;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];

  assign pc_inc = pc + ADDR_WIDTH'(1);
  // sp points at the next free slot; the top entry sits just below it
  assign top    = stack[sp - PW'(1)];

`ifdef RET_STACK_CHECK_EN
  logic ovf, ovf_n, unf, unf_n;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    sp_n    = sp;
    cnt_n   = cnt;
    push    = 1'b0;
`ifdef RET_STACK_CHECK_EN
    ovf_n   = ovf;
    unf_n   = unf;
`endif
    case (state)
      RUN: begin
        if (Stall) begin
          state_n = RUN;
        end else if (Halt) begin
          state_n = HALTED;
        end else if (Stack_Enable && Stack_Write) begin
`ifdef RET_STACK_CHECK_EN
          if (cnt == FULL) begin
            ovf_n   = 1'b1;
            state_n = FAULT;
          end else begin
            push  = 1'b1;
            pc_n  = Imm_Addr;
            sp_n  = sp + PW'(1);
            cnt_n = cnt + CW'(1);
          end
`else
          push  = 1'b1;
          pc_n  = Imm_Addr;
          sp_n  = sp + PW'(1);
          cnt_n = (cnt == FULL) ? cnt : cnt + CW'(1);
`endif
        end else if (Stack_Enable) begin
`ifdef RET_STACK_CHECK_EN
          if (cnt == '0) begin
            unf_n   = 1'b1;
            state_n = FAULT;
          end else begin
            pc_n  = top;
            sp_n  = sp - PW'(1);
            cnt_n = cnt - CW'(1);
          end
`else
          pc_n  = top;
          sp_n  = sp - PW'(1);
          cnt_n = (cnt == '0) ? cnt : cnt - CW'(1);
`endif
        end else if (Jump_R) begin
          pc_n = Reg_Addr;
        end else if (Jump_I || (Branch && Branch_Taken)) begin
          pc_n = Imm_Addr;
        end else begin
          pc_n = pc_inc;
        end
      end
      HALTED: begin
        if (Resume) begin
          pc_n    = pc_inc;
          state_n = RUN;
        end
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      pc    <= '0;
      sp    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      sp    <= sp_n;
      cnt   <= cnt_n;
    end
  end

`ifdef RET_STACK_CHECK_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_n;
      unf <= unf_n;
    end
  end
  assign Stack_Overflow  = ovf;
  assign Stack_Underflow = unf;
  assign Fault           = (state == FAULT);
`else
  assign Stack_Overflow  = 1'b0;
  assign Stack_Underflow = 1'b0;
  assign Fault           = 1'b0;
`endif

  // Contents are not reset; only the pointer/count define validity
  always_ff @(posedge Clk) begin
    if (push) stack[sp] <= pc_inc;
  end

  assign PC          = pc;
  assign Halted      = (state == HALTED);
  assign Stack_Count = cnt;
endmodule
